// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state encodings and latency counter width for the data-memory responder
package dmem_pkg;
  localparam int CNTW = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: 2^AW x 32 RAM, synchronous write, registered write-first read
module dmem_array #(
  parameter int    AW        = 10,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic          rzero,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= rzero ? '0 : (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store memory responder answering reads after RD_LAT cycles with a one-cycle valid pulse
// Ports: clk, rst (sync, active high); i_addr byte address (word index in [AW+1:2]); i_read_en held until
// o_read_vd; i_write_en/i_wdata single-cycle word write; o_rdata/o_read_vd registered read response;
// o_err sticky out-of-range flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    AW        = 10,
  parameter int    RD_LAT    = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_read_en,
  input  logic        i_write_en,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_read_vd,
  output logic        o_err
);
  state_t state;
  logic [CNTW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic oob_q;
  logic oob;
  logic start;
  logic last_wait;
  logic unused_ok;
  assign unused_ok = ^i_addr[1:0];
  assign oob = |i_addr[31:AW+2];
  assign start = state == ST_IDLE && i_read_en;
  // cnt holds the WAIT cycles still to run, so the final WAIT cycle is the one seeing cnt==1
  assign last_wait = state == ST_WAIT && i_read_en && cnt == CNTW'(1);
  dmem_array #(.AW(AW), .INIT_FILE(INIT_FILE)) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (i_write_en && !oob),
    .waddr(i_addr[AW+1:2]),
    .wdata(i_wdata),
    .re   (RD_LAT == 1 ? start : last_wait),
    .rzero(RD_LAT == 1 ? oob : oob_q),
    .raddr(RD_LAT == 1 ? i_addr[AW+1:2] : addr_q),
    .rdata(o_rdata)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      o_read_vd <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_read_vd <= 1'b0;
      if (oob && (i_write_en || start)) o_err <= 1'b1;
      case (state)
        ST_IDLE:
          if (i_read_en) begin
            addr_q    <= i_addr[AW+1:2];
            oob_q     <= oob;
            cnt       <= CNTW'(RD_LAT - 1);
            state     <= RD_LAT == 1 ? ST_RESP : ST_WAIT;
            o_read_vd <= RD_LAT == 1;
          end
        ST_WAIT:
          if (!i_read_en) state <= ST_IDLE;
          else if (cnt == CNTW'(1)) begin
            cnt       <= '0;
            state     <= ST_RESP;
            o_read_vd <= 1'b1;
          end else cnt <= cnt - CNTW'(1);
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
endmodule
